// File: rtl/datamem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : datamem_arbiter
// Purpose  : Shares a single-port data memory between port A (CPU load/store
//            unit) and port B (debug/DMA loader). Round-robin arbitration with
//            an optional bounded bus lock. Every request is screened for size,
//            alignment and range before it reaches memory. Responses come back
//            one cycle after the grant on a per-port rvalid/err/rdata triple.
// Ports    : clk, reset (async, active-high)
//            a_*/b_* : req, we, addr, wdata, size, lock in; gnt (comb),
//                      rvalid, rdata, err (registered) out
//            mem_*   : address, write/read enable, write data, xfer size out;
//                      read data in (combinational read)
// Revision : 1.0 - initial release
// ============================================================================
module datamem_arbiter #(
  parameter int DATA_MEM_SIZE = 1024,
  parameter int MAX_LOCK      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_size,
  input  logic        a_lock,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_size,
  input  logic        b_lock,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic [31:0] mem_address,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_xfer_size,
  input  logic [31:0] mem_read_data
);

  localparam int             CW       = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0]  LOCK_MAX = CW'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t        state;
  logic          last_b;     // 1 when B was granted most recently
  logic [CW-1:0] lock_cnt;
  logic          a_bad;
  logic          b_bad;

  // Reject unsupported sizes, misaligned addresses and any access whose end
  // lies past the memory. The end address is formed in 33 bits so a request
  // near 2^32 cannot wrap around and look in range.
  function automatic logic bad_req(input logic [31:0] addr, input logic [3:0] size);
    logic        size_ok;
    logic        misaligned;
    logic [32:0] end_addr;
    size_ok    = (size == 4'd1) || (size == 4'd2) || (size == 4'd4) || (size == 4'd8);
    misaligned = |(addr & {28'd0, size - 4'd1});
    end_addr   = {1'b0, addr} + {29'd0, size};
    return !size_ok || misaligned || (end_addr > 33'(DATA_MEM_SIZE));
  endfunction

  assign a_bad = bad_req(a_addr, a_size);
  assign b_bad = bad_req(b_addr, b_size);

  // Grant decision. Reset suppresses every grant so memory is never enabled
  // while reset is high.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (a_req && b_req) begin
            a_gnt = last_b;
            b_gnt = !last_b;
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
        end
        OWN_A: begin
          // Lock budget spent: the waiting port takes precedence.
          if (lock_cnt == LOCK_MAX && b_req) b_gnt = 1'b1;
          else                               a_gnt = a_req;
        end
        OWN_B: begin
          if (lock_cnt == LOCK_MAX && a_req) a_gnt = 1'b1;
          else                               b_gnt = b_req;
        end
        default: ;
      endcase
    end
  end

  // Memory side follows whichever port is granted; erroneous requests are
  // granted (so they get a response) but never enable the memory.
  assign mem_address      = b_gnt ? b_addr  : a_addr;
  assign mem_write_data   = b_gnt ? b_wdata : a_wdata;
  assign mem_xfer_size    = b_gnt ? b_size  : a_size;
  assign mem_write_enable = (a_gnt && a_we && !a_bad) || (b_gnt && b_we && !b_bad);
  assign mem_read_enable  = (a_gnt && !a_we && !a_bad) || (b_gnt && !b_we && !b_bad);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      lock_cnt <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt;
      b_rvalid <= b_gnt;
      a_err    <= a_gnt && a_bad;
      b_err    <= b_gnt && b_bad;
      a_rdata  <= (a_gnt && !a_we && !a_bad) ? mem_read_data : '0;
      b_rdata  <= (b_gnt && !b_we && !b_bad) ? mem_read_data : '0;

      if (a_gnt || b_gnt) last_b <= b_gnt;

      case (state)
        IDLE: begin
          if (a_gnt && a_lock && !a_bad) begin
            state    <= OWN_A;
            lock_cnt <= CW'(1);
          end else if (b_gnt && b_lock && !b_bad) begin
            state    <= OWN_B;
            lock_cnt <= CW'(1);
          end
        end
        OWN_A: begin
          if (a_gnt && a_lock && !a_bad) begin
            // Saturates: once at the limit the owner only keeps going while
            // the other port stays quiet.
            if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + CW'(1);
          end else begin
            state    <= IDLE;
            lock_cnt <= '0;
          end
        end
        OWN_B: begin
          if (b_gnt && b_lock && !b_bad) begin
            if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + CW'(1);
          end else begin
            state    <= IDLE;
            lock_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datamem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_datamem_arbiter
// Purpose  : Directed self-checking bench for datamem_arbiter, with a simple
//            byte-array model of the data memory (byte i preloaded with i).
// Revision : 1.0 - initial release
// ============================================================================
module tb_datamem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [3:0]  a_size, b_size;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;
  logic [3:0]  mem_xfer_size;

  int tests  = 0;
  int failed = 0;

  logic [7:0] mem [0:1023];

  always #5 clk = ~clk;

  datamem_arbiter #(.DATA_MEM_SIZE(1024), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_size(a_size), .a_lock(a_lock), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_size(b_size), .b_lock(b_lock), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .b_rdata(b_rdata), .b_err(b_err),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
    .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data)
  );

  // Memory model: writes store size bytes (bytes beyond the 32-bit bus are 0),
  // reads return the low min(size,4) bytes.
  always @(posedge clk) begin
    if (mem_write_enable) begin
      for (int i = 0; i < 8; i++)
        if (i < int'(mem_xfer_size))
          mem[10'(mem_address + 32'(i))] <= (i < 4) ? mem_write_data[8*i +: 8] : 8'h00;
    end
  end

  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(mem_xfer_size))
        mem_read_data[8*i +: 8] = mem[10'(mem_address + 32'(i))];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_size = 4'd4; a_lock = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_size = 4'd4; b_lock = 0;

    // Reset state, with A requesting while reset is held
    tick();
    a_req = 1; a_addr = 32'h10;
    #1;
    chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_read_enable}, 32'd0);
    chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk("rst_rdata", a_rdata | b_rdata, 32'd0);
    a_req = 0;
    tick();
    reset = 1'b0;

    // 1: lone A read, 4 bytes at 0x10
    a_req = 1; a_we = 0; a_addr = 32'h10; a_size = 4'd4;
    #1;
    chk("t1_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("t1_b_gnt", {31'd0, b_gnt}, 32'd0);
    chk("t1_rd_en", {31'd0, mem_read_enable}, 32'd1);
    chk("t1_addr", mem_address, 32'h10);
    tick();
    a_req = 0;
    chk("t1_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("t1_err", {31'd0, a_err}, 32'd0);
    chk("t1_rdata", a_rdata, 32'h13121110);
    tick();
    chk("t1_rvalid_drop", {31'd0, a_rvalid}, 32'd0);

    // 2: both request every cycle from reset, no lock -> A,B,A,B
    do_reset();
    a_req = 1; a_we = 0; a_addr = 32'h20; a_size = 4'd4;
    b_req = 1; b_we = 0; b_addr = 32'h40; b_size = 4'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_a_gnt", {31'd0, a_gnt}, {31'd0, (i % 2) == 0});
      chk("t2_b_gnt", {31'd0, b_gnt}, {31'd0, (i % 2) == 1});
      if (i % 2 == 1) begin
        chk("t2_a_rvalid", {31'd0, a_rvalid}, 32'd1);
        chk("t2_a_rdata", a_rdata, 32'h23222120);
      end else if (i > 0) begin
        chk("t2_b_rvalid", {31'd0, b_rvalid}, 32'd1);
        chk("t2_b_rdata", b_rdata, 32'h43424140);
      end
      tick();
    end
    a_req = 0; b_req = 0;
    chk("t2_b_last_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("t2_b_last_rdata", b_rdata, 32'h43424140);

    // 3: B writes 8 bytes at 0x20, A reads them back the next cycle
    b_req = 1; b_we = 1; b_addr = 32'h20; b_size = 4'd8; b_wdata = 32'hBEEFCAFE;
    #1;
    chk("t3_b_gnt", {31'd0, b_gnt}, 32'd1);
    chk("t3_wr_en", {31'd0, mem_write_enable}, 32'd1);
    chk("t3_wdata", mem_write_data, 32'hBEEFCAFE);
    chk("t3_size", {28'd0, mem_xfer_size}, 32'd8);
    tick();
    b_req = 0;
    a_req = 1; a_we = 0; a_addr = 32'h20; a_size = 4'd8;
    #1;
    chk("t3_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("t3_b_rvalid", {31'd0, b_rvalid}, 32'd1);
    chk("t3_b_rdata_wr", b_rdata, 32'd0);
    tick();
    a_req = 0;
    chk("t3_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("t3_a_rdata", a_rdata, 32'hBEEFCAFE);

    // 4: screening errors, then a legal access ending exactly at the top
    a_req = 1; a_we = 0; a_addr = 32'h6; a_size = 4'd4;
    #1;
    chk("t4a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("t4a_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    tick();
    a_req = 0;
    chk("t4a_resp", {30'd0, a_rvalid, a_err}, 32'd3);
    chk("t4a_rdata", a_rdata, 32'd0);
    b_req = 1; b_we = 0; b_addr = 32'h0; b_size = 4'd3;
    #1;
    chk("t4b_gnt", {31'd0, b_gnt}, 32'd1);
    chk("t4b_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    tick();
    b_req = 0;
    chk("t4b_resp", {30'd0, b_rvalid, b_err}, 32'd3);
    chk("t4b_rdata", b_rdata, 32'd0);
    a_req = 1; a_we = 1; a_addr = 32'h3FC; a_size = 4'd8; a_wdata = 32'h11111111;
    #1;
    chk("t4c_gnt", {31'd0, a_gnt}, 32'd1);
    chk("t4c_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    tick();
    a_we = 0; a_size = 4'd4;
    chk("t4c_resp", {30'd0, a_rvalid, a_err}, 32'd3);
    chk("t4c_rdata", a_rdata, 32'd0);
    #1;
    chk("t4d_rd_en", {31'd0, mem_read_enable}, 32'd1);
    tick();
    a_req = 0;
    chk("t4d_resp", {30'd0, a_rvalid, a_err}, 32'd2);
    chk("t4d_rdata", a_rdata, 32'hFFFEFDFC);

    // 5: A holds lock, B waits; MAX_LOCK=4 -> A A A A B A
    do_reset();
    a_req = 1; a_we = 0; a_addr = 32'h10; a_size = 4'd4; a_lock = 1;
    b_req = 1; b_we = 0; b_addr = 32'h40; b_size = 4'd4;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t5_a_gnt", {31'd0, a_gnt}, {31'd0, i != 4});
      chk("t5_b_gnt", {31'd0, b_gnt}, {31'd0, i == 4});
      chk("t5_b_rvalid", {31'd0, b_rvalid}, {31'd0, i == 5});
      tick();
    end
    a_req = 0; b_req = 0; a_lock = 0;
    chk("t5_a_rvalid", {31'd0, a_rvalid}, 32'd1);
    tick();

    // 6: reset asserted mid-cycle during a granted write
    a_req = 1; a_we = 1; a_addr = 32'h30; a_size = 4'd4; a_wdata = 32'hA5A5A5A5;
    #1;
    chk("t6_gnt", {31'd0, a_gnt}, 32'd1);
    chk("t6_wr_en", {31'd0, mem_write_enable}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_wr_en_rst", {31'd0, mem_write_enable}, 32'd0);
    chk("t6_gnt_rst", {31'd0, a_gnt}, 32'd0);
    tick();
    chk("t6_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("t6_mem", {24'd0, mem[10'h30]}, 32'h30);
    a_req = 0; a_we = 0;
    reset = 1'b0;
    tick();
    chk("t6_rvalid_after", {31'd0, a_rvalid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
